conv1_bias_relu: RTL and testbench

//  Post-accumulation stage for conv1. Takes one batch of NUM_CH raw conv1 accumulator

---
 rtl/conv1_bias_relu_if.sv | 71 +++++++
 rtl/conv1_bias_relu.sv | 149 ++++++++++++++
 tb/tb_conv1_bias_relu.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv1_bias_relu_if.sv
// conv1_bias_relu_if
//  Bundles the three buses of the conv1 post-accumulation stage:
//   - accumulator input stream  : in_valid / in_ready / in_batch / in_data
//   - bias ROM read port        : bias_aa / bias_cena / bias_qa
//   - activation output stream  : out_valid / out_ready / out_data / out_batch / out_last
//   - status                    : err_batch
//  Modports:
//   slave  : the conv1_bias_relu block itself
//   master : the surrounding environment (accumulator, bias ROM, pooling buffer)
//  All vectors are packed with channel 0 in the MSBs.
interface conv1_bias_relu_if #(
  parameter int unsigned NUM_CH = 6,
  parameter int unsigned W_ADDR = 1,
  parameter int unsigned W_ACC  = 26,
  parameter int unsigned W_OUT  = 8
);

  // Accumulator input stream
  logic                      in_valid;
  logic                      in_ready;
  logic [W_ADDR-1:0]         in_batch;
  logic [NUM_CH*W_ACC-1:0]   in_data;

  // Bias ROM read port (registered read, active-low enable)
  logic [W_ADDR-1:0]         bias_aa;
  logic                      bias_cena;
  logic [NUM_CH*W_ACC-1:0]   bias_qa;

  // Activation output stream
  logic                      out_valid;
  logic                      out_ready;
  logic [NUM_CH*W_OUT-1:0]   out_data;
  logic [W_ADDR-1:0]         out_batch;
  logic                      out_last;

  // Sticky status
  logic                      err_batch;

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_batch,
    input  in_data,
    output bias_aa,
    output bias_cena,
    input  bias_qa,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_batch,
    output out_last,
    output err_batch
  );

  modport master (
    output in_valid,
    input  in_ready,
    output in_batch,
    output in_data,
    input  bias_aa,
    input  bias_cena,
    output bias_qa,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_batch,
    input  out_last,
    input  err_batch
  );

endinterface

// File: rtl/conv1_bias_relu.sv
// conv1_bias_relu
//  Post-accumulation stage for conv1. Accepts one vector of NUM_CH signed accumulator
//  sums, reads the matching bias row from the conv1 bias ROM, and produces one vector of
//  NUM_CH unsigned W_OUT-bit activations:
//    s = acc + bias                      (W_ACC+1 bits, cannot overflow)
//    r = (s < 0) ? 0 : round(s / 2^SHIFT) (round half up)
//    a = min(r, 2^W_OUT-1)
//  Sequence: IDLE -> FETCH -> ADD -> OUT -> IDLE, so at most one vector is in flight.
//  Ports:
//   clk  : clock, all logic on the rising edge
//   rst  : synchronous reset, active-high; wins over every other event
//   bus  : conv1_bias_relu_if.slave (input stream, bias ROM port, output stream, status)
module conv1_bias_relu #(
  parameter int unsigned NUM_CH    = 6,
  parameter int unsigned NUM_BATCH = 1,
  parameter int unsigned W_ADDR    = 1,
  parameter int unsigned W_ACC     = 26,
  parameter int unsigned W_OUT     = 8,
  parameter int unsigned SHIFT     = 16
) (
  input  logic              clk,
  input  logic              rst,
  conv1_bias_relu_if.slave  bus
);

  // Working width for the rounding add: s is non-negative here and below 2^W_ACC, so
  // one extra bit above s keeps the rounding constant from overflowing.
  localparam int unsigned WRnd = W_ACC + 2;

  localparam logic [WRnd-1:0] RoundHalf = WRnd'(1) << (SHIFT - 1);
  localparam logic [WRnd-1:0] MaxAct    = {{(WRnd - W_OUT){1'b0}}, {W_OUT{1'b1}}};

  localparam logic [W_ADDR:0]   NumBatchExt = (W_ADDR + 1)'(NUM_BATCH);
  localparam logic [W_ADDR-1:0] LastBatch   = W_ADDR'(NUM_BATCH - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StAdd   = 2'd2;
  localparam logic [1:0] StOut   = 2'd3;

  logic [1:0]                r_state;
  logic [NUM_CH*W_ACC-1:0]   r_acc;
  logic [W_ADDR-1:0]         r_batch;
  logic                      r_bias_zero;
  logic                      r_err_batch;
  logic [W_ADDR-1:0]         r_bias_aa;
  logic                      r_bias_cena;
  logic                      r_out_valid;
  logic [NUM_CH*W_OUT-1:0]   r_out_data;
  logic [W_ADDR-1:0]         r_out_batch;
  logic                      r_out_last;

  logic                      w_bad_batch;
  logic [NUM_CH*W_OUT-1:0]   w_act;

  // Bias add, ReLU, rounding shift and unsigned saturation for one channel.
  function automatic logic [W_OUT-1:0] f_act(input logic [W_ACC-1:0] acc,
                                              input logic [W_ACC-1:0] bias);
    logic [W_ACC:0]  sum;
    logic [WRnd-1:0] rnd;
    logic [WRnd-1:0] res;
    sum = {acc[W_ACC-1], acc} + {bias[W_ACC-1], bias};
    rnd = {1'b0, sum} + RoundHalf;
    res = rnd >> SHIFT;
    if (sum[W_ACC]) begin
      f_act = '0;
    end else if (res > MaxAct) begin
      f_act = {W_OUT{1'b1}};
    end else begin
      f_act = res[W_OUT-1:0];
    end
  endfunction

  assign w_bad_batch = ({1'b0, bus.in_batch} >= NumBatchExt);

  // bias_qa is only sampled in ADD, the cycle after the ROM was enabled.
  always_comb begin
    w_act = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_act[(NUM_CH-1-c)*W_OUT +: W_OUT] =
        f_act(r_acc[(NUM_CH-1-c)*W_ACC +: W_ACC],
              r_bias_zero ? {W_ACC{1'b0}} : bus.bias_qa[(NUM_CH-1-c)*W_ACC +: W_ACC]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_acc       <= '0;
      r_batch     <= '0;
      r_bias_zero <= 1'b0;
      r_err_batch <= 1'b0;
      r_bias_aa   <= '0;
      r_bias_cena <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_batch <= '0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.in_valid) begin
            r_acc       <= bus.in_data;
            r_batch     <= bus.in_batch;
            // ROM still sees the raw index; the result just ignores its data.
            r_bias_aa   <= bus.in_batch;
            r_bias_cena <= 1'b0;
            r_bias_zero <= w_bad_batch;
            if (w_bad_batch) begin
              r_err_batch <= 1'b1;
            end
            r_state     <= StFetch;
          end
        end
        StFetch: begin
          // ROM samples address on this edge; enable is low for this single cycle.
          r_bias_cena <= 1'b1;
          r_state     <= StAdd;
        end
        StAdd: begin
          r_out_data  <= w_act;
          r_out_batch <= r_batch;
          r_out_last  <= (r_batch == LastBatch);
          r_out_valid <= 1'b1;
          r_state     <= StOut;
        end
        StOut: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == StIdle);
  assign bus.bias_aa   = r_bias_aa;
  assign bus.bias_cena = r_bias_cena;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_batch = r_out_batch;
  assign bus.out_last  = r_out_last;
  assign bus.err_batch = r_err_batch;

endmodule

// File: tb/tb_conv1_bias_relu.sv
// tb_conv1_bias_relu
//  Directed bench for conv1_bias_relu with a behavioural bias ROM (registered read,
//  active-low enable). Expected activations are hand-computed from the bias row.
module tb_conv1_bias_relu;

  localparam int NCH = 6;
  localparam int WA  = 26;
  localparam int WO  = 8;

  logic clk;
  logic rst;

  int n_cmp;
  int n_mis;

  conv1_bias_relu_if #(.NUM_CH(NCH), .W_ADDR(1), .W_ACC(WA), .W_OUT(WO)) bus ();

  conv1_bias_relu #(
    .NUM_CH(NCH), .NUM_BATCH(1), .W_ADDR(1), .W_ACC(WA), .W_OUT(WO), .SHIFT(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NCH*WA-1:0] pack6(input logic signed [WA-1:0] a,
                                              input logic signed [WA-1:0] b,
                                              input logic signed [WA-1:0] c,
                                              input logic signed [WA-1:0] d,
                                              input logic signed [WA-1:0] e,
                                              input logic signed [WA-1:0] f);
    return {a, b, c, d, e, f};
  endfunction

  // Bias ROM: row 0 is the real conv1 bias, row 1 is junk that must never be used.
  logic [NCH*WA-1:0] rom [2];
  initial begin
    rom[0] = pack6(26'sd816700, 26'sd218092, 26'sd3719360, 26'sd777449,
                   -26'sd5816779, 26'sd1286717);
    rom[1] = pack6(26'sd3000000, 26'sd3000000, 26'sd3000000, 26'sd3000000,
                   26'sd3000000, 26'sd3000000);
  end

  always @(posedge clk) begin
    if (!bus.bias_cena) bus.bias_qa <= rom[bus.bias_aa];
  end

  // Send one vector, wait for out_valid (bounded) and complete the handshake at once.
  // lat counts falling edges after the accepting edge until out_valid is seen.
  task automatic run_vec(input logic [0:0] batch, input logic [NCH*WA-1:0] data,
                         output logic [NCH*WO-1:0] got, output logic [0:0] got_batch,
                         output logic got_last, output int lat, output int cena_lo,
                         output bit ok);
    int guard;
    ok = 1'b1; lat = 0; cena_lo = 0; guard = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_batch = batch;
    bus.in_data  = data;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) ok = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    if (!bus.bias_cena) cena_lo++;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (!bus.bias_cena) cena_lo++;
    end
    if (!bus.out_valid) ok = 1'b0;
    got       = bus.out_data;
    got_batch = bus.out_batch;
    got_last  = bus.out_last;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_batch !== 1'b0 ||
        bus.out_last !== 1'b0 || bus.err_batch !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_outputs got v=%b d=%h b=%b l=%b e=%b want all zero",
               bus.out_valid, bus.out_data, bus.out_batch, bus.out_last, bus.err_batch);
    end
    n_cmp++;
    if (bus.bias_cena !== 1'b1 || bus.bias_aa !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_rom got cena=%b aa=%b want cena=1 aa=0", bus.bias_cena, bus.bias_aa);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_zero_input();
    logic [NCH*WO-1:0] got;
    logic [0:0] gb;
    logic gl;
    int lat, cl;
    bit ok;
    run_vec(1'b0, '0, got, gb, gl, lat, cl, ok);
    n_cmp++;
    if (got !== {8'd12, 8'd3, 8'd57, 8'd12, 8'd0, 8'd20} || !ok) begin
      n_mis++;
      $display("FAIL zero_data got %h ok=%0d want 0c03390c0014", got, ok);
    end
    n_cmp++;
    if (gl !== 1'b1 || gb !== 1'b0) begin
      n_mis++;
      $display("FAIL zero_last got last=%b batch=%b want last=1 batch=0", gl, gb);
    end
    n_cmp++;
    if (lat !== 3) begin
      n_mis++;
      $display("FAIL zero_latency got %0d want 3", lat);
    end
    n_cmp++;
    if (cl !== 1) begin
      n_mis++;
      $display("FAIL zero_cena_cycles got %0d want 1", cl);
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL zero_after_hs got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_rounding();
    logic [NCH*WO-1:0] got;
    logic [0:0] gb;
    logic gl;
    int lat, cl;
    bit ok;
    run_vec(1'b0, pack6(-26'sd587324, 0, 0, 0, 0, 0), got, gb, gl, lat, cl, ok);
    n_cmp++;
    if (got !== {8'd4, 8'd3, 8'd57, 8'd12, 8'd0, 8'd20} || !ok) begin
      n_mis++;
      $display("FAIL round_half_up got %h ok=%0d want 0403390c0014", got, ok);
    end
    run_vec(1'b0, pack6(-26'sd816700, 0, 0, 0, 0, 0), got, gb, gl, lat, cl, ok);
    n_cmp++;
    if (got !== {8'd0, 8'd3, 8'd57, 8'd12, 8'd0, 8'd20} || !ok) begin
      n_mis++;
      $display("FAIL round_zero_sum got %h ok=%0d want 0003390c0014", got, ok);
    end
  endtask

  task automatic test_saturation();
    logic [NCH*WO-1:0] got;
    logic [0:0] gb;
    logic gl;
    int lat, cl;
    bit ok;
    logic signed [WA-1:0] vmax, vmin;
    vmax = 26'sd33554431;
    vmin = 26'h2000000;
    run_vec(1'b0, pack6(vmax, vmax, vmax, vmax, vmax, vmax), got, gb, gl, lat, cl, ok);
    n_cmp++;
    if (got !== {6{8'd255}} || !ok) begin
      n_mis++;
      $display("FAIL sat_high got %h ok=%0d want ffffffffffff", got, ok);
    end
    run_vec(1'b0, pack6(vmin, vmin, vmin, vmin, vmin, vmin), got, gb, gl, lat, cl, ok);
    n_cmp++;
    if (got !== '0 || !ok) begin
      n_mis++;
      $display("FAIL sat_low got %h ok=%0d want 000000000000", got, ok);
    end
  endtask

  task automatic test_backpressure();
    logic [NCH*WO-1:0] exp_a;
    logic [NCH*WO-1:0] exp_b;
    logic signed [WA-1:0] m;
    int guard;
    m     = 26'sd1048576;
    exp_a = {8'd12, 8'd3, 8'd57, 8'd12, 8'd0, 8'd20};
    exp_b = {8'd28, 8'd19, 8'd73, 8'd28, 8'd0, 8'd36};
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_batch = 1'b0;
    bus.in_data  = '0;
    @(negedge clk);
    // Vector B waits on the input while A is in flight.
    bus.in_data = pack6(m, m, m, m, m, m);
    guard = 0;
    while (!bus.out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin
      n_mis++;
      $display("FAIL bp_first_valid got %b want 1", bus.out_valid);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.out_data !== exp_a || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        n_mis++;
        $display("FAIL bp_hold[%0d] got d=%h v=%b rdy=%b want d=%h v=1 rdy=0",
                 i, bus.out_data, bus.out_valid, bus.in_ready, exp_a);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_mis++;
      $display("FAIL bp_release got rdy=%b v=%b want rdy=1 v=0", bus.in_ready, bus.out_valid);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.in_ready !== 1'b0 || bus.bias_cena !== 1'b0) begin
      n_mis++;
      $display("FAIL bp_next_accept got rdy=%b cena=%b want rdy=0 cena=0",
               bus.in_ready, bus.bias_cena);
    end
    guard = 0;
    while (!bus.out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (bus.out_data !== exp_b || bus.out_valid !== 1'b1) begin
      n_mis++;
      $display("FAIL bp_second_data got %h v=%b want %h v=1", bus.out_data, bus.out_valid, exp_b);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_in_add();
    logic [NCH*WO-1:0] got;
    logic [0:0] gb;
    logic gl;
    int lat, cl;
    bit ok;
    bit seen;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_batch = 1'b0;
    bus.in_data  = pack6(-26'sd587324, 0, 0, 0, 0, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.bias_cena !== 1'b1 || bus.out_data !== '0 ||
        bus.out_batch !== 1'b0 || bus.out_last !== 1'b0) begin
      n_mis++;
      $display("FAIL rst_add_outputs got v=%b cena=%b d=%h b=%b l=%b want 0,1,0,0,0",
               bus.out_valid, bus.bias_cena, bus.out_data, bus.out_batch, bus.out_last);
    end
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_mis++;
      $display("FAIL rst_add_no_output got out_valid seen=%0d want 0", seen);
    end
    run_vec(1'b0, '0, got, gb, gl, lat, cl, ok);
    n_cmp++;
    if (got !== {8'd12, 8'd3, 8'd57, 8'd12, 8'd0, 8'd20} || !ok || lat !== 3) begin
      n_mis++;
      $display("FAIL rst_add_fresh got %h ok=%0d lat=%0d want 0c03390c0014 ok=1 lat=3",
               got, ok, lat);
    end
  endtask

  task automatic test_bad_index();
    logic [NCH*WO-1:0] got;
    logic [0:0] gb;
    logic gl;
    int lat, cl;
    bit ok;
    logic signed [WA-1:0] m;
    m = 26'sd1048576;
    n_cmp++;
    if (bus.err_batch !== 1'b0) begin
      n_mis++;
      $display("FAIL bad_err_before got %b want 0", bus.err_batch);
    end
    run_vec(1'b1, pack6(m, m, m, m, m, m), got, gb, gl, lat, cl, ok);
    n_cmp++;
    if (got !== {6{8'd16}} || !ok) begin
      n_mis++;
      $display("FAIL bad_data got %h ok=%0d want 101010101010", got, ok);
    end
    n_cmp++;
    if (gb !== 1'b1 || gl !== 1'b0 || bus.err_batch !== 1'b1) begin
      n_mis++;
      $display("FAIL bad_flags got batch=%b last=%b err=%b want 1,0,1", gb, gl, bus.err_batch);
    end
    run_vec(1'b0, '0, got, gb, gl, lat, cl, ok);
    n_cmp++;
    if (got !== {8'd12, 8'd3, 8'd57, 8'd12, 8'd0, 8'd20} || bus.err_batch !== 1'b1) begin
      n_mis++;
      $display("FAIL bad_sticky got d=%h err=%b want 0c03390c0014 err=1", got, bus.err_batch);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (bus.err_batch !== 1'b0) begin
      n_mis++;
      $display("FAIL bad_err_cleared got %b want 0", bus.err_batch);
    end
  endtask

  initial begin
    n_cmp         = 0;
    n_mis         = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_batch  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.bias_qa   = '0;
    test_reset();
    test_zero_input();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_reset_in_add();
    test_bad_index();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
